// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver.
// Inputs are snapshotted once per frame; outputs are registered and active-low.
module seg7_scan_driver #(
    parameter logic [15:0] TICK_CNT  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic        scan_tick
);

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_data;
    logic [3:0]  r_dp;
    logic [3:0]  r_en;
    logic        r_lz;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_seg_dp;
    logic        r_tick;

    logic        w_wrap;
    logic [3:0]  w_nib;
    logic [3:0]  w_nz;
    logic        w_sup;
    logic        w_on;
    logic [6:0]  w_glyph;
    logic [3:0]  w_an;
    logic [6:0]  w_seg;
    logic        w_seg_dp;

    assign w_wrap = (r_cnt == TICK_CNT - 16'd1);
    assign w_nib  = r_data[{r_idx, 2'b00} +: 4];

    assign w_nz[0] = |r_data[3:0];
    assign w_nz[1] = |r_data[7:4];
    assign w_nz[2] = |r_data[11:8];
    assign w_nz[3] = |r_data[15:12];

    // A digit is a leading zero when it and every digit to its left are zero
    always_comb begin
        w_sup = 1'b0;
        unique case (r_idx)
            2'd0: w_sup = 1'b0;
            2'd1: w_sup = r_lz && !(|w_nz[3:1]);
            2'd2: w_sup = r_lz && !(|w_nz[3:2]);
            2'd3: w_sup = r_lz && !w_nz[3];
        endcase
    end

    always_comb begin
        w_glyph = 7'b1111111;
        unique case (w_nib)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            4'hF: w_glyph = 7'b0001110;
        endcase
    end

    // Blank window at slot start hides the anode/segment switchover
    assign w_on = (r_cnt >= BLANK_CYC) && r_en[r_idx] && !w_sup;

    always_comb begin
        w_an     = 4'b1111;
        w_seg    = 7'b1111111;
        w_seg_dp = 1'b1;
        if (w_on) begin
            w_an     = ~(4'b0001 << r_idx);
            w_seg    = w_glyph;
            w_seg_dp = ~r_dp[r_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_dp     <= '0;
            r_en     <= '0;
            r_lz     <= 1'b0;
            r_an     <= 4'b1111;
            r_seg    <= 7'b1111111;
            r_seg_dp <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            r_tick   <= w_wrap;
            r_an     <= w_an;
            r_seg    <= w_seg;
            r_seg_dp <= w_seg_dp;
            if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_data <= data;
                    r_dp   <= dp;
                    r_en   <= digit_en;
                    r_lz   <= lz_blank;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign seg_dp    = r_seg_dp;
    assign scan_tick = r_tick;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed 4-digit common-anode 7-segment display driver for the board debug display.
- Runs on the single system clock and derives the per-digit scan rate from an internal prescaler; it does not use a divided clock.
- Shows a 16-bit hex value with per-digit enable, decimal points and optional leading-zero suppression.
- Captures its inputs once per frame, so a frame never shows a mix of old and new values.

Parameters:
- TICK_CNT, 16'd50000, clock cycles per digit slot (slot rate 2 kHz at 100 MHz; 500 Hz frame rate). Must be ≥ BLANK_CYC+2.
- BLANK_CYC, 16'd16, cycles at the start of each slot during which all anodes and segments are off (anti-ghosting).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- data  in  16  hex value; digit i shows data[4i+3:4i], digit 0 is rightmost
- dp  in  4  decimal point per digit, 1 = lit
- digit_en  in  4  per-digit enable, 0 = digit dark
- lz_blank  in  1  1 = suppress leading zeros
- an  out  4  anode enables, active-low, one-hot-low when driven
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- seg_dp  out  1  decimal point, active-low
- scan_tick  out  1  one-cycle pulse at each slot boundary

Behaviour:
- Reset (async, immediate, no clock edge needed): cnt=0, idx=0, all shadow registers=0, an=4'b1111, seg=7'b1111111, seg_dp=1, scan_tick=0.
- Prescaler cnt:
  - 16-bit counter, 0..TICK_CNT-1; increments every cycle.
  - At TICK_CNT-1 it wraps to 0 and idx advances; idx is 2-bit and wraps 3→0.
- Frame snapshot: on the wrap with idx==3, data/dp/digit_en/lz_blank load into shadow registers. Display logic uses only shadows.
  - Consequence: the first frame after reset is fully dark (shadow enables = 0).
  - Inputs take effect from the slot-0 that follows the next frame boundary.
- Digit visibility: slot idx is visible iff shadow_en[idx]=1 and the digit is not suppressed.
  - Suppressed iff shadow lz_blank=1, idx≠0, and nibbles idx..3 are all zero. Digit 0 is never suppressed.
- Output function, evaluated from the current cnt/idx/shadows and registered, so outputs lag state by exactly 1 cycle:
  - cnt < BLANK_CYC, or digit not visible: an=4'b1111, seg=7'b1111111, seg_dp=1.
  - Otherwise: an = ~(4'b0001<<idx), seg = glyph(nibble idx), seg_dp = ~shadow_dp[idx].
- Glyphs use the standard hex set, with b and d lowercase. Required codes:
  - 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 5=7'b0010010, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
- scan_tick: registered; high for exactly one cycle, the cycle after cnt==TICK_CNT-1. Period is TICK_CNT cycles.
- At most one anode is low in any cycle. an is never low while seg holds a stale glyph from another slot (the blank window covers the switch).
- Input changes mid-frame: no effect until the next frame boundary. Changes exactly on the boundary cycle are captured.
- Reset mid-slot: outputs go dark asynchronously. After release, scanning restarts at idx=0, cnt=0, and the first frame is dark.

Test Plan (TICK_CNT=8, BLANK_CYC=2):
- Reset held 20 cycles, then released → an=4'b1111, seg=7'h7F, seg_dp=1 throughout; scan_tick first pulses 8 cycles after release, then every 8.
- data=16'h1234, digit_en=4'hF, dp=0, lz_blank=0 → frame 1 (cycles 0–31) dark. In frame 2:
  - slot 0: an=4'b1110, seg=7'b0011001 (4), on cycles cnt 2..7 (+1 lag).
  - slot 3: an=4'b0111, seg=7'b1111001 (1).
  - an=4'b1111 during cnt 0..1 of every slot.
- In frame 2, change data to 16'h8888 during slot 1 → slots 1–3 still show 3,2,1; frame 3 shows seg=7'b0000000 on all four digits.
- lz_blank=1 with data=16'h0050 → slots 3,2 dark, slot 1 shows 5 (7'b0010010), slot 0 shows 0. With data=16'h0000, only slot 0 shows 0.
- digit_en=4'b0101, dp=4'b0001 → an low only in slots 0 and 2; seg_dp=0 only in slot 0; slots 1 and 3 fully dark.
- Assert reset mid-slot 2 while an=4'b1011 → an=4'b1111 and seg=7'h7F in the same cycle, before any clk edge. After release, the next frame is dark and the first scan_tick comes after 8 cycles.
